// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// One radix-2 shift-add / restoring shift-subtract datapath for all M ops.
module muldiv_unit #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         startE,
   input  logic         flushE,
   input  logic [2:0]   funct3E,
   input  logic [W-1:0] srcaE,
   input  logic [W-1:0] srcbE,
   output logic         busyE,
   output logic         doneE,
   output logic [W-1:0] resultE
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] CMAX = CW'(W - 1);
   localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] acc;
   logic [W-1:0]   opb;
   logic [2:0]     f3;
   logic           qneg;
   logic           rneg;

   logic           isdiv;
   logic           asgn;
   logic           bsgn;
   logic           an;
   logic           bn;
   logic [W-1:0]   amag;
   logic [W-1:0]   bmag;
   logic           divz;
   logic           ovf;
   logic [W-1:0]   spec;

   logic [W-1:0]   madd;
   logic [W:0]     msum;
   logic [W:0]     dtry;
   logic [2*W-1:0] mstep;
   logic [2*W-1:0] dstep;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;
   logic [W-1:0]   fixres;

   // operand signedness and divide special cases, decoded at issue
   always_comb begin
      isdiv = funct3E[2];
      asgn  = 1'b0;
      bsgn  = 1'b0;
      unique case (1'b1)
         isdiv:                begin asgn = ~funct3E[0]; bsgn = ~funct3E[0]; end
         funct3E == 3'b001:    begin asgn = 1'b1; bsgn = 1'b1; end
         funct3E == 3'b010:    begin asgn = 1'b1; bsgn = 1'b0; end
         default:              begin asgn = 1'b0; bsgn = 1'b0; end
      endcase
      an   = asgn & srcaE[W-1];
      bn   = bsgn & srcbE[W-1];
      amag = an ? -srcaE : srcaE;
      bmag = bn ? -srcbE : srcbE;
      divz = isdiv & (srcbE == '0);
      ovf  = isdiv & ~funct3E[0] & (srcaE == SMIN) & (srcbE == '1);
      if (divz)
         spec = funct3E[1] ? srcaE : '1;
      else
         spec = funct3E[1] ? '0 : srcaE;
   end

   // one iteration of either datapath
   always_comb begin
      madd  = acc[0] ? opb : '0;
      msum  = {1'b0, acc[2*W-1:W]} + {1'b0, madd};
      mstep = {msum, acc[W-1:1]};
      dtry  = acc[2*W-1:W-1] - {1'b0, opb};
      if (dtry[W])
         dstep = {acc[2*W-2:0], 1'b0};
      else
         dstep = {dtry[W-1:0], acc[W-2:0], 1'b1};
   end

   always_comb begin
      prod = qneg ? -acc : acc;
      quo  = qneg ? -acc[W-1:0] : acc[W-1:0];
      rem  = rneg ? -acc[2*W-1:W] : acc[2*W-1:W];
      if (f3[2])
         fixres = f3[1] ? rem : quo;
      else if (f3[1:0] == 2'b00)
         fixres = prod[W-1:0];
      else
         fixres = prod[2*W-1:W];
   end

   assign busyE = rst_n & ((state == IDLE & startE & ~flushE) |
                           state == CALC | state == FIX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         opb     <= '0;
         f3      <= '0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         doneE   <= 1'b0;
         resultE <= '0;
      end else if (flushE) begin
         state <= IDLE;
         doneE <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               doneE <= 1'b0;
               if (startE) begin
                  f3   <= funct3E;
                  qneg <= an ^ bn;
                  rneg <= an;
                  cnt  <= CMAX;
                  if (divz | ovf) begin
                     resultE <= spec;
                     doneE   <= 1'b1;
                     state   <= DONE;
                  end else begin
                     opb   <= isdiv ? bmag : amag;
                     acc   <= {{W{1'b0}}, isdiv ? amag : bmag};
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= f3[2] ? dstep : mstep;
               cnt <= cnt - 1'b1;
               if (cnt == '0)
                  state <= FIX;
            end
            FIX: begin
               resultE <= fixres;
               doneE   <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               doneE <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
